dff_delay_line: RTL and testbench
=================================

Name: dff_delay_line

Overview:
- Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage registered delay line.
- Adds a clock enable (stall), a synchronous flush, per-stage valid tracking, a selectable tap output and an occupancy counter.
- Used wherever datapath signals must be retimed or delayed by a fixed number of cycles alongside a valid qualifier.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 4: number of register stages (>=1).
- RESET_VAL, 0: value loaded into every data stage on reset and on flush (WIDTH bits).
- TAP_W, max(1, clog2(DEPTH)): derived; width of tap_sel.
- CNT_W, clog2(DEPTH+1): derived; width of fill_cnt.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset asserted).
- en  input  1  advance enable; 1 = shift one stage this edge, 0 = hold.
- clr  input  1  synchronous flush, priority over en.
- d  input  WIDTH  data into stage 0.
- d_valid  input  1  qualifier for d.
- tap_sel  input  TAP_W  stage index for the tap output (0 = first stage).
- q  output  WIDTH  data of the last stage (DEPTH-1).
- q_valid  output  1  valid of the last stage.
- tap_q  output  WIDTH  data of the stage selected by tap_sel.
- tap_valid  output  1  valid of the stage selected by tap_sel.
- fill_cnt  output  CNT_W  number of stages currently holding valid data.
- full  output  1  fill_cnt == DEPTH.

Behaviour:
- Storage: stage[0..DEPTH-1] (WIDTH bits each) plus vld[0..DEPTH-1] and a registered fill_cnt.
- Reset (reset=0): asynchronous; takes effect immediately without a clock edge.
  - All stage = RESET_VAL; all vld = 0; fill_cnt = 0.
  - Consequently q = RESET_VAL, q_valid = 0, full = 0.
  - Outputs hold these values while reset is low.
  - Release is synchronous to the next rising edge; the first capture can occur on the first edge after reset goes high.
- Per rising edge, in priority order:
  - clr=1: all stage = RESET_VAL, all vld = 0, fill_cnt = 0. en, d and d_valid are ignored.
  - en=1:
    - stage[0] <= d and vld[0] <= d_valid.
    - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i = 1..DEPTH-1.
    - fill_cnt <= fill_cnt + d_valid - vld[DEPTH-1].
  - en=0: all state holds.
- Data moves regardless of valid: invalid entries still shift through with their data, and q reflects them.
- Latency: with en=1 continuously, d sampled at edge k appears on q after edge k+DEPTH-1. For DEPTH=1 this is the same edge, matching a plain D flip-flop.
- Stall: en=0 on intervening edges adds one cycle of latency per stalled edge. No data is lost or duplicated.
- Simultaneous input and output of valid data (d_valid=1, vld[DEPTH-1]=1, en=1): fill_cnt is unchanged.
- fill_cnt never exceeds DEPTH and never underflows. full is asserted combinationally from fill_cnt.
- Tap output: tap_q and tap_valid are combinational muxes of registered state, so tap_sel changes are visible in the same cycle.
  - tap_sel >= DEPTH (out of range): tap_q = RESET_VAL, tap_valid = 0.
- Outputs q, q_valid and fill_cnt are driven directly from registers, with no combinational path from d.
- Reset mid-stream: all in-flight data is discarded immediately. Post-reset behaviour is identical to power-up.
- No X propagation from state: every register has a defined reset value.

Test Plan:
- WIDTH=8, DEPTH=4, RESET_VAL=0. Hold reset=0 for 20 ns, release. Drive en=1, d_valid=1, d=0x11,0x22,0x33,0x44 on consecutive edges -> q=0x11 with q_valid=1 after the 4th edge; fill_cnt reaches 4 and full=1; next edges give q=0x22, 0x33, 0x44.
- Continuous stream with en=0 for 2 edges mid-stream -> q sequence unchanged and delayed by exactly 2 cycles; fill_cnt constant while stalled.
- Pipeline full (fill_cnt=4), then assert clr=1 together with en=1 and d=0xAA -> after that edge q=0x00, q_valid=0, fill_cnt=0, full=0; 0xAA is not captured.
- Alternate d_valid=1,0 with d=0x01..0x08 and en=1 -> q_valid alternates at q; fill_cnt settles at 2; data of invalid entries still appears on q.
- Pipeline loaded with 0x11..0x44, en=0; sweep tap_sel 0..3 -> tap_q=0x44,0x33,0x22,0x11 with tap_valid=1 in the same cycle. DEPTH=5 build with tap_sel=7 -> tap_q=RESET_VAL, tap_valid=0.
- Drop reset to 0 mid-stream between clock edges -> q, q_valid and fill_cnt clear immediately, before the next edge. DEPTH=1 build: d=0x5A sampled at an edge gives q=0x5A after that same edge.

Source files
------------

// File: rtl/dff_delay_line.sv
// WIDTH-bit, DEPTH-stage registered delay line with a valid bit per stage.
// Features: advance enable, synchronous flush, selectable tap and an occupancy count.
module dff_delay_line #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             d_valid_i,
    input  logic [TAP_W-1:0] tap_sel_i,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o,
    output logic [WIDTH-1:0] tap_q_o,
    output logic             tap_valid_o,
    output logic [CNT_W-1:0] fill_cnt_o,
    output logic             full_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = RESET_VAL;
            end
            vld_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            stage_d[0] = d_i;
            vld_d[0]   = d_valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
            // Entering and leaving valid entries cancel, so the count stays within 0..DEPTH.
            cnt_d = cnt_q + CNT_W'(d_valid_i) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    // Out-of-range selects fall through to the reset value with no valid.
    always_comb begin
        tap_q_o     = RESET_VAL;
        tap_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel_i == TAP_W'(i)) begin
                tap_q_o     = stage_q[i];
                tap_valid_o = vld_q[i];
            end
        end
    end

    assign q_o        = stage_q[DEPTH-1];
    assign q_valid_o  = vld_q[DEPTH-1];
    assign fill_cnt_o = cnt_q;
    assign full_o     = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: DEPTH=4, DEPTH=5 (non-zero reset value) and DEPTH=1 builds share
// one stimulus stream and are compared against an array-based model of the stage contents.
module tb_dff_delay_line;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_valid;
    logic [1:0] ts4;
    logic [2:0] ts5;
    logic       ts1;

    logic [7:0] q4, tq4, q5, tq5, q1, tq1;
    logic       qv4, tv4, f4, qv5, tv5, f5, qv1, tv1, f1;
    logic [2:0] fc4, fc5;
    logic       fc1;

    int checks = 0;
    int errors = 0;

    int         dep [3] = '{4, 5, 1};
    logic [7:0] rv  [3] = '{8'h00, 8'hA5, 8'h00};
    logic [7:0] md  [3][5];
    logic       mv  [3][5];

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clr_i(clr), .d_i(d), .d_valid_i(d_valid),
        .tap_sel_i(ts4), .q_o(q4), .q_valid_o(qv4), .tap_q_o(tq4), .tap_valid_o(tv4),
        .fill_cnt_o(fc4), .full_o(f4));

    dff_delay_line #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'hA5)) dut5 (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clr_i(clr), .d_i(d), .d_valid_i(d_valid),
        .tap_sel_i(ts5), .q_o(q5), .q_valid_o(qv5), .tap_q_o(tq5), .tap_valid_o(tv5),
        .fill_cnt_o(fc5), .full_o(f5));

    dff_delay_line #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .clr_i(clr), .d_i(d), .d_valid_i(d_valid),
        .tap_sel_i(ts1), .q_o(q1), .q_valid_o(qv1), .tap_q_o(tq1), .tap_valid_o(tv1),
        .fill_cnt_o(fc1), .full_o(f1));

    function automatic void m_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 5; i++) begin
                md[k][i] = rv[k];
                mv[k][i] = 1'b0;
            end
    endfunction

    // Model: each stage is a slot; an enabled edge moves every entry one slot toward the output.
    function automatic void m_step();
        if (clr) begin
            m_reset();
        end else if (en) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = dep[k] - 1; i > 0; i--) begin
                    md[k][i] = md[k][i-1];
                    mv[k][i] = mv[k][i-1];
                end
                md[k][0] = d;
                mv[k][0] = d_valid;
            end
        end
    endfunction

    function automatic int m_fill(int k);
        int n = 0;
        for (int i = 0; i < dep[k]; i++) n += int'(mv[k][i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k, input logic [7:0] q, input logic qv, input logic [7:0] tq,
                           input logic tv, input int fc, input logic f, input int ts);
        int fill = m_fill(k);
        chk($sformatf("q%0d", dep[k]), {24'd0, q}, {24'd0, md[k][dep[k]-1]});
        chk($sformatf("q_valid%0d", dep[k]), {31'd0, qv}, {31'd0, mv[k][dep[k]-1]});
        chk($sformatf("fill_cnt%0d", dep[k]), fc, fill);
        chk($sformatf("full%0d", dep[k]), {31'd0, f}, {31'd0, fill == dep[k]});
        chk($sformatf("tap_q%0d", dep[k]), {24'd0, tq}, {24'd0, (ts < dep[k]) ? md[k][ts] : rv[k]});
        chk($sformatf("tap_valid%0d", dep[k]), {31'd0, tv}, {31'd0, (ts < dep[k]) ? mv[k][ts] : 1'b0});
    endtask

    task automatic check_all();
        chk_dut(0, q4, qv4, tq4, tv4, int'(fc4), f4, int'(ts4));
        chk_dut(1, q5, qv5, tq5, tv5, int'(fc5), f5, int'(ts5));
        chk_dut(2, q1, qv1, tq1, tv1, int'(fc1), f1, int'(ts1));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) m_step();
        else m_reset();
        #1;
        check_all();
    endtask

    task automatic drive(input logic e, input logic c, input logic [7:0] dd, input logic dv);
        en = e; clr = c; d = dd; d_valid = dv;
    endtask

    initial begin
        int fc_hold;
        m_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        ts4 = 2'd0; ts5 = 3'd0; ts1 = 1'b0;
        #10;
        check_all();
        chk("reset_q4", {24'd0, q4}, 32'h00);
        #10;
        reset_n = 1'b1;

        // Fill with 0x11..0x44, then drain.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 8'(i * 8'h11), 1'b1);
            cycle();
        end
        chk("first_out_q", {24'd0, q4}, 32'h11);
        chk("first_out_full", {31'd0, f4}, 32'd1);
        chk("first_out_fill", {29'd0, fc4}, 32'd4);

        // Tap sweep with the pipeline held.
        drive(1'b0, 1'b0, 8'h99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ts4 = 2'(i);
            #1;
            chk("tap_sweep", {24'd0, tq4}, 32'(8'h44 - 8'(i * 8'h11)));
            chk("tap_sweep_valid", {31'd0, tv4}, 32'd1);
        end
        ts5 = 3'd7;
        #1;
        chk("tap_oor_q5", {24'd0, tq5}, 32'hA5);
        chk("tap_oor_valid5", {31'd0, tv5}, 32'd0);

        // Flush wins over enable; 0xAA must not be captured.
        drive(1'b1, 1'b1, 8'hAA, 1'b1);
        ts4 = 2'd0;
        cycle();
        chk("clr_q", {24'd0, q4}, 32'h00);
        chk("clr_fill", {29'd0, fc4}, 32'd0);
        chk("clr_tap0", {24'd0, tq4}, 32'h00);

        // Alternating valid stream.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 8'(i), (i % 2) == 1);
            cycle();
        end
        chk("alt_fill", {29'd0, fc4}, 32'd2);

        // Stall two edges mid-stream; occupancy must hold.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b1);
            cycle();
        end
        fc_hold = int'(fc4);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'hEE, 1'b0);
            cycle();
        end
        chk("stall_fill", {29'd0, fc4}, 32'(fc_hold));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h70 + i), 1'b1);
            cycle();
        end

        // Single-stage build behaves as a plain flop.
        drive(1'b1, 1'b0, 8'h5A, 1'b1);
        cycle();
        chk("depth1_q", {24'd0, q1}, 32'h5A);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("async_rst_fill", {29'd0, fc4}, 32'd0);
        cycle();
        #2;
        reset_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                  8'($urandom), 1'($urandom));
            ts4 = 2'($urandom);
            ts5 = 3'($urandom);
            ts1 = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
